muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative multiply/divide unit paired with the single-cycle ALU in the CPU datapath. Executes MULT, MULTU, DIV and DIVU on WIDTH-bit operands over WIDTH+1 cycles and owns the architectural HI/LO registers, including MTHI/MTLO writes. The control unit stalls the pipeline on `busy`. MFHI/MFLO read `hi`/`lo` directly.

## Interface
- `WIDTH`, default 32: operand width and HI/LO width. Must be at least 4.
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous reset, active-high.
- `start` in 1: request an operation. Sampled only when `busy`=0.
- `op` in 2: operation, encoded as MULT=00, MULTU=01, DIV=10, DIVU=11.
- `a` in WIDTH: rs operand. Multiplicand or dividend.
- `b` in WIDTH: rt operand. Multiplier or divisor.
- `hi_we` in 1: MTHI write enable.
- `lo_we` in 1: MTLO write enable.
- `wdata` in WIDTH: MTHI/MTLO data.
- `busy` out 1: operation in progress.
- `done` out 1: one-cycle pulse when HI/LO take a new result.
- `div_zero` out 1: sticky flag. Last DIV/DIVU had `b`=0.
- `hi` out WIDTH: HI register.
- `lo` out WIDTH: LO register.

## Operation
- States are IDLE, CALC and FIX. Reset puts the unit in IDLE.
- IDLE with `start`=1:
  - latch `op`;
  - for signed ops, latch |a| and |b| plus the result signs;
  - for MULT/DIV, quotient/product sign = a[W-1]^b[W-1], remainder sign = a[W-1];
  - clear the iteration counter and go to CALC.
- CALC runs exactly WIDTH iterations, one per cycle:
  - multiply: shift-add on a 2*WIDTH accumulator;
  - divide: restoring, 1 quotient bit per cycle, using a WIDTH+1-bit partial remainder.
- FIX:
  - apply two's-complement sign correction;
  - write HI/LO, pulse `done`, return to IDLE.
- Multiply: {hi,lo} = full 2*WIDTH-bit product. Signed for MULT, unsigned for MULTU.
- Divide: lo = quotient, hi = remainder. Truncation toward zero, so the remainder takes the dividend's sign.
- Divide by zero, decided result: lo = all ones, hi = a (original, unsigned view). `div_zero` is set. The iterations still run, so latency is unchanged.
- `div_zero` is cleared by the next DIV/DIVU that completes with nonzero `b`. MULT/MULTU leave it unchanged.
- Signed overflow (DIV of most-negative by −1): lo = 100…0, hi = 0. No flag.
- |most-negative| is handled as an unsigned WIDTH-bit magnitude. No extra width is needed.
- MTHI/MTLO:
  - in IDLE, `hi_we`/`lo_we` write `wdata` next edge; both may be set together;
  - while `busy`=1, writes are ignored (the control unit stalls them);
  - in IDLE, `start` and a write in the same cycle: `start` wins and the write is dropped.
- `start` while `busy`=1 is ignored. No queuing.
- `a`/`b` may change after the start cycle. The unit uses only the latched values.

## Timing
- Reset values: `busy`=0, `done`=0, `div_zero`=0, `hi`=0, `lo`=0, state IDLE, all internal registers 0.
- Let the edge sampling `start` be E0:
  - `busy`=1 after E0;
  - iterations occur at E1…E_WIDTH;
  - at E_WIDTH+1, `hi`/`lo`/`div_zero` update, `done`=1 and `busy`=0.
- Latency start→result is WIDTH+1 cycles (33 at default). `busy` is high for WIDTH+1 cycles.
- `done` is high for exactly one cycle.
- Back-to-back: during the `done` cycle `busy`=0, so a new `start` in that cycle is accepted.
- `hi`/`lo` hold the previous result until the FIX edge. Intermediate values are never visible.
- Reset mid-operation: on the next edge the unit returns to IDLE, hi/lo=0, with no `done` pulse.

## Structure
- `muldiv_pkg` holds:
  - op encodings `OP_MULT`, `OP_MULTU`, `OP_DIV`, `OP_DIVU`;
  - the state enum `{ST_IDLE, ST_CALC, ST_FIX}`.
- Sub-module `muldiv_step`, combinational: one shift-add step or one restoring-divide step, selected by a mul/div select. It is instantiated once inside `muldiv_unit`.
- Counter width: $clog2(WIDTH)+1.

## Test plan
- MULT a=0x00000007, b=0xFFFFFFFD → hi=0xFFFFFFFF, lo=0xFFFFFFEB. `done` exactly 33 cycles after start.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001. Then MULT with the same operands → hi=0, lo=1.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU a=0x12345678, b=0 → lo=0xFFFFFFFF, hi=0x12345678, `div_zero`=1. A following DIVU 10/3 → lo=3, hi=1, `div_zero`=0.
- Control scenarios:
  - `start` and `hi_we` pulsed mid-operation are ignored;
  - a new `start` in the `done` cycle is accepted;
  - `rst` at iteration 10 gives IDLE, hi=lo=0 and no `done`;
  - MTLO 0xCAFE in IDLE gives lo=0xCAFE next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings,
// FSM state type and small op-decode helpers.
package muldiv_pkg;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CALC,
        ST_FIX
    } state_t;

    // MULT and DIV operate on two's-complement operands
    function automatic logic is_signed_op(input logic [1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

    function automatic logic is_div_op(input logic [1:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: a shift-add multiply step or a
// restoring-divide step on the {hi_in, lo_in} accumulator pair.
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             div_sel,
    input  logic [WIDTH:0]   hi_in,
    input  logic [WIDTH-1:0] lo_in,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH:0]   hi_out,
    output logic [WIDTH-1:0] lo_out
);

    logic [WIDTH:0]   sum;
    logic [WIDTH+1:0] shifted;
    logic [WIDTH+1:0] diff;
    logic             neg;

    always_comb begin
        sum     = lo_in[0] ? (hi_in + {1'b0, operand}) : hi_in;
        shifted = {hi_in, lo_in[WIDTH-1]};
        diff    = shifted - {2'b00, operand};
        neg     = diff[WIDTH+1];
        hi_out  = '0;
        lo_out  = '0;
        if (div_sel) begin
            // restore on borrow; quotient bit enters from the bottom of lo
            hi_out = neg ? shifted[WIDTH:0] : diff[WIDTH:0];
            lo_out = {lo_in[WIDTH-2:0], ~neg};
        end else begin
            hi_out = {1'b0, sum[WIDTH:1]};
            lo_out = {sum[0], lo_in[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers,
// WIDTH+1 cycles per operation, with MTHI/MTLO writes accepted while idle.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned PROD_W = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   mag_a_q, mag_a_d;
    logic [WIDTH-1:0]   mag_b_q, mag_b_d;
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]     acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;

    logic               sgn_in;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     step_hi;
    logic [WIDTH-1:0]   step_lo;
    logic [PROD_W-1:0]  prod;
    logic [PROD_W-1:0]  prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   a_orig;

    // operand magnitudes; |most-negative| fits as an unsigned WIDTH-bit value
    assign sgn_in = is_signed_op(op);
    assign a_mag  = (sgn_in && a[WIDTH-1]) ? (WIDTH'(0) - a) : a;
    assign b_mag  = (sgn_in && b[WIDTH-1]) ? (WIDTH'(0) - b) : b;

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .div_sel (is_div_op(op_q)),
        .hi_in   (acc_hi_q),
        .lo_in   (acc_lo_q),
        .operand (is_div_op(op_q) ? mag_b_q : mag_a_q),
        .hi_out  (step_hi),
        .lo_out  (step_lo)
    );

    // sign-corrected results, consumed only in ST_FIX
    assign prod     = {acc_hi_q[WIDTH-1:0], acc_lo_q};
    assign prod_fix = q_neg_q ? (PROD_W'(0) - prod) : prod;
    assign quo_fix  = q_neg_q ? (WIDTH'(0) - acc_lo_q) : acc_lo_q;
    assign rem_fix  = r_neg_q ? (WIDTH'(0) - acc_hi_q[WIDTH-1:0]) : acc_hi_q[WIDTH-1:0];
    assign a_orig   = r_neg_q ? (WIDTH'(0) - mag_a_q) : mag_a_q;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        op_d     = op_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        cnt_d    = cnt_q;
        acc_hi_d = acc_hi_q;
        acc_lo_d = acc_lo_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    // start takes priority over a same-cycle MTHI/MTLO
                    state_d  = ST_CALC;
                    busy_d   = 1'b1;
                    op_d     = op;
                    mag_a_d  = a_mag;
                    mag_b_d  = b_mag;
                    q_neg_d  = sgn_in && (a[WIDTH-1] ^ b[WIDTH-1]);
                    r_neg_d  = sgn_in && a[WIDTH-1];
                    cnt_d    = '0;
                    acc_hi_d = '0;
                    acc_lo_d = is_div_op(op) ? a_mag : b_mag;
                end else begin
                    if (hi_we) begin
                        hi_d = wdata;
                    end
                    if (lo_we) begin
                        lo_d = wdata;
                    end
                end
            end
            ST_CALC: begin
                acc_hi_d = step_hi;
                acc_lo_d = step_lo;
                cnt_d    = cnt_q + CNT_W'(1);
                if (cnt_q == LAST_ITER) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (is_div_op(op_q)) begin
                    if (mag_b_q == '0) begin
                        lo_d = '1;
                        hi_d = a_orig;
                        dz_d = 1'b1;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                        dz_d = 1'b0;
                    end
                end else begin
                    hi_d = prod_fix[PROD_W-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            op_q     <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            cnt_q    <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            op_q     <= op_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            cnt_q    <= cnt_d;
            acc_hi_q <= acc_hi_d;
            acc_lo_q <= acc_lo_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: stimulus pushes hand-computed results,
// a monitor pops and checks them whenever done pulses.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam int W = 32;
    localparam int LAT = W + 1;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         hi_we, lo_we;
    logic [W-1:0] wdata;
    logic         busy, done, div_zero;
    logic [W-1:0] hi, lo;

    typedef struct {
        int           id;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
        int           t0;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   done_seen = 0;
    int   vid = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // called at the negedge before the sampling edge
    task automatic push_exp(input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
        exp_t e;
        vid++;
        e.id = vid; e.hi = eh; e.lo = el; e.dz = edz; e.t0 = cyc;
        sbq.push_back(e);
    endtask

    task automatic drive_start(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb);
        start = 1'b1; op = o; a = aa; b = bb;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 3 * LAT; i++) begin
            @(negedge clk);
            if (!busy) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_vec++; n_miss++;
            $display("FAIL wait_idle: got busy stuck high expected busy=0 within %0d cycles", 3 * LAT);
        end
    endtask

    task automatic run_op(input logic [1:0] o, input logic [W-1:0] aa, input logic [W-1:0] bb,
                          input logic [W-1:0] eh, input logic [W-1:0] el, input logic edz);
        @(negedge clk);
        drive_start(o, aa, bb);
        push_exp(eh, el, edz);
        @(negedge clk);
        start = 1'b0; a = '1; b = '1;
        wait_idle();
    endtask

    // monitor: compare every done pulse against the oldest expectation
    always begin
        @(posedge clk);
        #1;
        if (done) begin
            done_seen++;
            if (sbq.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_done: got done=1 expected no pending result (hi=%h lo=%h)", hi, lo);
            end else begin
                mon_e = sbq.pop_front();
                chk($sformatf("v%0d_hi", mon_e.id), 64'(hi), 64'(mon_e.hi));
                chk($sformatf("v%0d_lo", mon_e.id), 64'(lo), 64'(mon_e.lo));
                chk($sformatf("v%0d_div_zero", mon_e.id), 64'(div_zero), 64'(mon_e.dz));
                chk($sformatf("v%0d_latency", mon_e.id), 64'(cyc - mon_e.t0 - 1), 64'(LAT));
            end
        end
    end

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_div_zero", 64'(div_zero), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);

        // signed/unsigned multiply
        run_op(OP_MULT, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", 64'(done), 64'd0);
        run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op(OP_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0);

        // signed divide, truncation and overflow
        run_op(OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op(OP_DIV, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
        run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0);

        // divide by zero, flag kept by multiply, cleared by a good divide
        run_op(OP_DIVU, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF, 1'b1);
        run_op(OP_MULTU, 32'h0000_0003, 32'h0000_0005, 32'h0000_0000, 32'h0000_000F, 1'b1);
        run_op(OP_DIVU, 32'h0000_000A, 32'h0000_0003, 32'h0000_0001, 32'h0000_0003, 1'b0);
        run_op(OP_DIV,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b1);

        // start and MTHI pulsed mid-operation are ignored
        @(negedge clk);
        drive_start(OP_DIVU, 32'd100, 32'd7);
        push_exp(32'd2, 32'd14, 1'b0);
        @(negedge clk);
        start = 1'b0; a = '1; b = '1;
        repeat (4) @(negedge clk);
        drive_start(OP_MULT, 32'h0000_0009, 32'h0000_0009);
        hi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start = 1'b0; hi_we = 1'b0;
        chk("midop_busy", 64'(busy), 64'd1);
        wait_idle();

        // back-to-back: new start accepted in the done cycle
        run_op(OP_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006, 1'b0);
        chk("b2b_done_cycle", 64'(done), 64'd1);
        drive_start(OP_DIVU, 32'hFFFF_FFFF, 32'h0000_0010);
        push_exp(32'h0000_000F, 32'h0FFF_FFFF, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_accepted", 64'(busy), 64'd1);
        wait_idle();

        // start wins over a same-cycle MTLO
        @(negedge clk);
        drive_start(OP_MULTU, 32'd2, 32'd2);
        lo_we = 1'b1; wdata = 32'h0000_1111;
        push_exp(32'd0, 32'd4, 1'b0);
        @(negedge clk);
        start = 1'b0; lo_we = 1'b0;
        wait_idle();

        // reset at iteration 10: back to idle, hi/lo cleared, no done
        @(negedge clk);
        drive_start(OP_MULTU, 32'h0000_1234, 32'h0000_5678);
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        seen = done_seen;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_busy", 64'(busy), 64'd0);
        chk("midrst_done", 64'(done), 64'd0);
        chk("midrst_hi", 64'(hi), 64'd0);
        chk("midrst_lo", 64'(lo), 64'd0);
        repeat (2 * LAT) @(negedge clk);
        chk("midrst_no_done", 64'(done_seen), 64'(seen));

        // MTLO / MTHI while idle
        lo_we = 1'b1; wdata = 32'h0000_CAFE;
        @(negedge clk);
        lo_we = 1'b0;
        chk("mtlo_lo", 64'(lo), 64'h0000_CAFE);
        chk("mtlo_hi", 64'(hi), 64'd0);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_5A5A;
        @(negedge clk);
        hi_we = 1'b0; lo_we = 1'b0;
        chk("mthilo_hi", 64'(hi), 64'hA5A5_5A5A);
        chk("mthilo_lo", 64'(lo), 64'hA5A5_5A5A);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sbq.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
